// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that locks the shared UART transmitter to one requester per message.
// Optional lock watchdog: define UART_TX_ARB_TIMEOUT_EN to revoke a lock after TIMEOUT_CYC idle cycles.
module uart_tx_arb #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               tx_valid_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_ready_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               timeout_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = 16;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("uart_tx_arb: parameter out of range");
  end

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] pick_idx, cand;
  logic             pick_found;
  logic             owner_valid, owner_last, xfer;
  logic [7:0]       req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data_i[8*g +: 8];
  end

  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign xfer        = (state_q == ST_LOCKED) && owner_valid && tx_ready_i;

  // First valid requester scanning upward from the one after the last owner
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % N_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wd_cnt_d  = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_LOCKED;
          owner_d = pick_idx;
        end
      end
      ST_LOCKED: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        // Idle-cycle count saturates at the limit
        if (!owner_valid) begin
          wd_cnt_d = (wd_cnt_q == CNT_W'(TIMEOUT_CYC)) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
        end
`endif
        if (xfer && owner_last) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (wd_cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          state_d   = ST_IDLE;
          ptr_d     = owner_q;
          timeout_d = 1'b1;
          wd_cnt_d  = '0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: owner's handshake passes straight through while locked
  always_comb begin
    req_ready_o = '0;
    grant_o     = '0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    if (state_q == ST_LOCKED) begin
      grant_o     = N_REQ'(1) << owner_q;
      req_ready_o = tx_ready_i ? (N_REQ'(1) << owner_q) : '0;
      tx_valid_o  = owner_valid;
      tx_data_o   = req_bytes[owner_q];
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (two requesters).
module tb_uart_tx_arb;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  int snap0, snap1;

  uart_tx_arb #(.N_REQ(2), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .tx_ready_i(tx_ready), .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (grant == 2'b01) cnt0 <= cnt0 + 1;
      if (grant == 2'b10) cnt1 <= cnt1 + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
    tick(); tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_txvalid", 32'(tx_valid), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_txdata", 32'(tx_data), 0);
    rst = 1'b0;

    // Three-byte message from requester 0 while requester 1 waits
    req_valid = 2'b11; req_data = 16'h9941; req_last = 2'b10; tx_ready = 1'b1;
    #1;
    check("idle_grant", 32'(grant), 0);
    check("idle_txvalid", 32'(tx_valid), 0);
    tick();
    check("m3_grant", 32'(grant), 32'h1);
    check("m3_ready", 32'(req_ready), 32'h1);
    check("m3_b0", 32'(tx_data), 32'h41);
    tick();
    req_data[7:0] = 8'h42; #1;
    check("m3_b1", 32'(tx_data), 32'h42);
    check("m3_hold_grant", 32'(grant), 32'h1);
    tick();
    req_data[7:0] = 8'h43; req_last = 2'b11; #1;
    check("m3_b2", 32'(tx_data), 32'h43);
    tick();
    req_valid = 2'b10; #1;
    check("bubble_grant", 32'(grant), 0);
    check("bubble_txvalid", 32'(tx_valid), 0);
    tick();
    check("r1_grant", 32'(grant), 32'h2);
    check("r1_data", 32'(tx_data), 32'h99);
    check("r1_ready", 32'(req_ready), 32'h2);
    check("r0_bytes", 32'(cnt0), 3);
    tick();
    req_valid = 2'b00; #1;
    check("r1_done", 32'(grant), 0);

    // Backpressure: byte stays stable while tx_ready is low
    req_valid = 2'b01; req_data = 16'h0010; req_last = 2'b01; tx_ready = 1'b0;
    tick();
    snap0 = cnt0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(tx_valid), 1);
      check("bp_data", 32'(tx_data), 32'h10);
      check("bp_ready", 32'(req_ready), 0);
      tick();
    end
    tx_ready = 1'b1; #1;
    check("bp_release", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00; #1;
    check("bp_one_xfer", 32'(cnt0 - snap0), 1);
    check("bp_idle", 32'(grant), 0);

    // Fairness: both stream single-byte messages
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 2'b11; req_last = 2'b11; req_data = 16'hB0A0; tx_ready = 1'b1;
    snap0 = cnt0; snap1 = cnt1;
    #1;
    for (int m = 0; m < 8; m++) begin
      check("rr_bubble", 32'(grant), 0);
      tick();
      check("rr_grant", 32'(grant), (m % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_data", 32'(tx_data), (m % 2 == 0) ? 32'hA0 : 32'hB0);
      tick();
    end
    req_valid = 2'b00; #1;
    check("rr_cnt0", 32'(cnt0 - snap0), 4);
    check("rr_cnt1", 32'(cnt1 - snap1), 4);

    // Reset mid-message from requester 1
    req_valid = 2'b10; req_last = 2'b00; req_data = 16'h5500;
    tick();
    check("mr_grant1", 32'(grant), 32'h2);
    tick();
    rst = 1'b1; req_valid = 2'b11; req_data = 16'h55C0; req_last = 2'b01;
    tick();
    rst = 1'b0; #1;
    check("mr_grant0", 32'(grant), 0);
    check("mr_txvalid", 32'(tx_valid), 0);
    tick();
    check("mr_first", 32'(grant), 32'h1);
    check("mr_data", 32'(tx_data), 32'hC0);
    tick();
    req_valid = 2'b00; req_last = 2'b00;

    // Owner 1 stalls after one non-last byte with requester 0 pending
    req_valid = 2'b10; req_data = 16'h7700;
    tick();
    check("st_grant", 32'(grant), 32'h2);
    tick();
    req_valid = 2'b01; req_data = 16'h77D0; req_last = 2'b01; #1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check("wd_hold", 32'(grant), 32'h2);
      check("wd_nopulse", 32'(timeout), 0);
      check("wd_txvalid", 32'(tx_valid), 0);
      tick();
    end
    check("wd_pulse", 32'(timeout), 1);
    check("wd_idle", 32'(grant), 0);
    tick();
    check("wd_next", 32'(grant), 32'h1);
    check("wd_pulse_end", 32'(timeout), 0);
    tick();
`else
    for (int i = 0; i < 10; i++) begin
      check("lock_hold", 32'(grant), 32'h2);
      check("lock_timeout", 32'(timeout), 0);
      tick();
    end
    req_valid = 2'b11; req_data = 16'h78D0; req_last = 2'b11; #1;
    check("lock_resume", 32'(tx_data), 32'h78);
    tick();
    req_valid = 2'b01; #1;
    check("lock_idle", 32'(grant), 0);
    tick();
    check("lock_next", 32'(grant), 32'h1);
    check("lock_next_data", 32'(tx_data), 32'hD0);
    tick();
`endif
    req_valid = 2'b00; #1;
    check("end_idle", 32'(grant), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
- REQ-001 SHALL have parameter N_REQ, default 2: number of requesters sharing the UART transmitter, range 2..8.
- REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: idle cycles before a held lock is revoked, range 2..65535.
- REQ-003 SHALL have port clk_i  input  1: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst_i  input  1: reset, synchronous and active-high.
- REQ-005 SHALL have port req_valid_i  input  N_REQ: per-requester byte valid.
- REQ-006 SHALL have port req_data_i  input  8*N_REQ: per-requester byte, where requester k uses bits [8k+7:8k].
- REQ-007 SHALL have port req_last_i  input  N_REQ: marks the byte as the final byte of that requester's message.
- REQ-008 SHALL have port req_ready_o  output  N_REQ: per-requester byte accept.
- REQ-009 SHALL have port tx_valid_o  output  1: byte valid towards the UART transmitter.
- REQ-010 SHALL have port tx_data_o  output  8: byte towards the UART transmitter.
- REQ-011 SHALL have port tx_ready_i  input  1: the UART transmitter accepts the byte.
- REQ-012 SHALL have port grant_o  output  N_REQ: one-hot current lock owner, all-zero when no owner.
- REQ-013 SHALL have port timeout_o  output  1: one-cycle pulse when a lock is revoked by the watchdog.

Function
- REQ-014 SHALL implement the states IDLE and LOCKED, plus a registered owner index and a registered round-robin pointer (last owner).
- REQ-015 In IDLE: all req_ready_o=0, tx_valid_o=0, tx_data_o=0, grant_o=0, and no transfer SHALL occur.
- REQ-016 In IDLE with any req_valid_i set, the block SHALL select the first valid requester scanning upward from pointer+1 modulo N_REQ, and SHALL enter LOCKED with that owner on the next edge. Grant latency is exactly 1 cycle.
- REQ-017 In LOCKED: tx_valid_o, tx_data_o and req_ready_o[owner] SHALL follow req_valid_i[owner], req_data_i[owner] and tx_ready_i combinationally. Non-owner ready SHALL be 0, and grant_o SHALL be one-hot on the owner.
- REQ-018 A transfer SHALL occur when tx_valid_o and tx_ready_i are both high; no bytes are lost, duplicated or reordered.
- REQ-019 A transfer with req_last_i[owner]=1 SHALL return the block to IDLE on the next edge and set pointer=owner. Re-arbitration happens the following cycle even if requests are pending, so there is a 1-cycle bubble between messages.
- REQ-020 Non-owner requests arriving during LOCKED SHALL be held off (ready=0), never dropped, and SHALL be arbitrated at the next IDLE.
- REQ-021 A requester that finishes a message and immediately requests again SHALL be served only after every other valid requester, so no requester starves.
- REQ-022 A message of length 1 (last on the first byte) SHALL take exactly 2 cycles from IDLE with valid to return to IDLE, given tx_ready_i=1.

Reset
- REQ-023 With rst_i high at an edge, the next state SHALL be IDLE, pointer=N_REQ-1 (so requester 0 wins first), watchdog counter=0 and timeout_o=0. All outputs SHALL then take their REQ-015 values.
- REQ-024 Reset asserted mid-message SHALL drop the lock without completing the message. The requester SHALL restart its message after reset.

Configuration
- REQ-025 Macro UART_TX_ARB_TIMEOUT_EN defined: in LOCKED, a counter SHALL increment each cycle that req_valid_i[owner]=0 and clear on any cycle it is 1. On reaching TIMEOUT_CYC it SHALL force IDLE, set pointer=owner and pulse timeout_o for 1 cycle.
- REQ-026 The watchdog counter SHALL saturate and never wrap. A transfer in the same cycle the count reaches TIMEOUT_CYC is impossible, because valid is low.
- REQ-027 Macro UART_TX_ARB_TIMEOUT_EN undefined: no counter SHALL be implemented, the lock SHALL be held until a last byte transfers, and timeout_o SHALL be tied to 0.

Verification
- REQ-028 Reset, then req_valid_i=2'b11 with tx_ready_i=1 -> grant_o=2'b01 one cycle later; requester 0's 3-byte message 0x41,0x42,0x43 (last on 0x43) appears on tx_data_o in order, then after 1 IDLE cycle grant_o=2'b10.
- REQ-029 Owner 0 sends 0x10 with tx_ready_i held low for 5 cycles -> tx_valid_o=1 and tx_data_o=0x10 stable for all 5 cycles, req_ready_o=0, and exactly one transfer when tx_ready_i rises.
- REQ-030 Both requesters continuously sending single-byte messages -> grants alternate 01,10,01,10 for 8 messages, and each requester transfers 4 bytes.
- REQ-031 UART_TX_ARB_TIMEOUT_EN with TIMEOUT_CYC=4: owner 1 drops valid after 1 non-last byte -> timeout_o pulses on the 4th idle cycle, the block goes to IDLE, and a pending requester 0 is granted next.
- REQ-032 rst_i asserted for 1 cycle while owner 1 is mid-message -> the next cycle shows grant_o=0 and tx_valid_o=0, and with both valid, requester 0 is granted first.
